uart_rx_deserializer: RTL
=========================

// Module: uart_rx_deserializer
// PURPOSE
//  - UART receive path: recovers 8N1 frames (8E1 with UART_RX_PARITY_EN) from serial line iRx.
//  - Outputs each byte with a one-cycle valid strobe. Flags framing errors.
//  - Sits between the keyboard serial pin and the scan-code logic; counterpart of the UART transmitter.
//  - Has its own bit timer, dividing the 50 MHz iClk. It does not consume an external baud tick.
// PARAMETERS
//  - BAUD_RATE  9600      line rate in bit/s; DIV = 50000000/BAUD_RATE (5208 at default), HALF = DIV/2
//  - DATA_BITS  8         data bits per frame, LSB first
// PORTS
//  - iClk         in   1   50 MHz system clock
//  - iRst         in   1   asynchronous reset, active-low
//  - iRx          in   1   serial line, idle high, asynchronous to iClk
//  - oData        out  8   last good byte; holds until the next good frame
//  - oValid       out  1   one-cycle pulse: oData updated this cycle
//  - oFrame_err   out  1   one-cycle pulse: stop bit sampled low
//  - oParity_err  out  1   one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
//  - oBusy        out  1   high in every state except IDLE
// BEHAVIOUR
//  - Reset: oData=0, oValid=0, oFrame_err=0, oParity_err=0, oBusy=0, state=IDLE, sync flops=1.
//  - Input sync: iRx passes through a 2-flop synchronizer (rx_s). Edge detect uses a third flop (rx_d).
//  - Bit timer: 13-bit counter, reloaded at every state entry, expires at DIV-1 (HALF-1 in START).
//  - Counter width is sized for DIV up to 8191. BAUD_RATE below 6104 is illegal.
//  - IDLE: a falling edge (rx_d=1, rx_s=0) -> START, counter=0.
//  - START: at HALF-1, sample rx_s.
//    - If rx_s=1 -> glitch, return to IDLE with no error pulse.
//    - If rx_s=0 -> DATA with bit index 0.
//  - DATA: every DIV cycles, shift rx_s into the MSB of the shift register (LSB-first line order).
//    - After DATA_BITS samples -> PARITY (macro on) or STOP (macro off).
//  - PARITY: after DIV cycles, sample rx_s and compare with even parity over the shifted data. Then -> STOP.
//  - STOP: after DIV cycles, sample rx_s.
//    - If rx_s=1 and parity is ok: oData<=shift register, oValid=1 for one cycle -> IDLE.
//    - If rx_s=1 and parity fails: oParity_err=1, oData unchanged -> IDLE.
//    - If rx_s=0: oFrame_err=1, oData unchanged -> WAIT_HIGH. A framing error also suppresses any parity error.
//  - WAIT_HIGH: stay until rx_s=1 (break / line stuck low), then -> IDLE. No start detect while here.
//  - Latency: oValid asserts about (DATA_BITS+1.5)*DIV + 3 cycles after the iRx falling edge.
//  - Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge right after the stop bit is caught.
//  - Status pulses are mutually exclusive and never held. There is no downstream backpressure; the consumer must take oData on oValid.
//  - Reset asserted mid-frame aborts immediately to reset values. A partial frame is never reported.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined: adds the PARITY state and an even-parity check; 11-bit frame; oParity_err live.
//  - UART_RX_PARITY_EN undefined: no PARITY state, 10-bit frame, oParity_err tied to 1'b0.
// STRUCTURE
//  - Package uart_pkg: CLK_HZ=50000000, state encodings (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH), function baud_div(rate).
//  - Sub-module uart_rx_sync: 2-flop synchronizer plus edge-detect flop, reset to 1.
//  - Timer, FSM and shift register stay in this module.
// TESTING
//  - Send 0xA5 8N1 at 9600 (DIV=5208) -> one oValid pulse, oData=0xA5, oFrame_err=0, oBusy low after.
//  - Low glitch of 1000 cycles on an idle line -> back to IDLE by cycle ~2607, no pulses, oData unchanged.
//  - Frame 0x3C with stop bit driven low, line then held low 3 bit times -> oFrame_err pulse.
//    - oData keeps the prior value; no oValid until a new frame arrives after the line rises.
//  - Two back-to-back frames 0x00 then 0xFF, zero idle gap -> two oValid pulses, values in order.
//  - Assert iRst during bit 4 of a frame -> all outputs 0 at once.
//    - Next full frame 0x5A after release -> oData=0x5A.
//  - Parity, with UART_RX_PARITY_EN: 0x07 with parity bit 1 -> oValid.
//    - Same byte with parity bit 0 -> oParity_err pulse, oData unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and baud divider helper for the UART receiver
package uart_pkg;

    localparam int CLK_HZ = 50000000;

    // Bit timer width; holds DIV values up to 8191.
    localparam int CNT_W = 13;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    function automatic int baud_div(input int rate);
        return CLK_HZ / rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line plus one edge-detect flop
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_d
);

    logic rx_meta;

    // Flops reset to 1 so an idle line never looks like a start edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receive path, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRx,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oFrame_err,
    output logic       oParity_err,
    output logic       oBusy
);

    localparam int DIV   = baud_div(BAUD_RATE);
    localparam int HALF  = DIV / 2;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   rx_s;
    logic                   rx_d;
    logic                   cnt_clr;
    logic                   shift_en;
    logic                   valid_nxt;
    logic                   ferr_nxt;
    logic                   perr_nxt;
    logic                   par_ok;

    uart_rx_sync u_sync (
        .clk   (iClk),
        .rst_n (iRst),
        .rx    (iRx),
        .rx_s  (rx_s),
        .rx_d  (rx_d)
    );

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par_smp;

    // Latch the even-parity verdict when the parity bit is sampled.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst)
            par_ok <= 1'b1;
        else if (par_smp)
            par_ok <= ~(^shift ^ rx_s);
    end
`else
    localparam state_t AFTER_DATA = STOP;
    assign par_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and per-cycle strobes; timer expiry drives every sampling decision.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        perr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (rx_d && !rx_s)
                    state_nxt = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == DIV_M1) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == LAST_IDX)
                        state_nxt = AFTER_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == DIV_M1) begin
                    cnt_clr   = 1'b1;
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == DIV_M1) begin
                    cnt_clr = 1'b1;
                    if (!rx_s) begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end else begin
                        valid_nxt = par_ok;
                        perr_nxt  = ~par_ok;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_clr = 1'b1;
                if (rx_s)
                    state_nxt = IDLE;
            end
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit timer, bit index and shift register; data arrives LSB first so it enters at the MSB.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (state != DATA)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + IDX_W'(1);
            if (shift_en)
                shift <= {rx_s, shift[DATA_BITS-1:1]};
        end
    end

    // Registered outputs: data only updates on a good frame, status pulses last one cycle.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oData       <= 8'h00;
            oValid      <= 1'b0;
            oFrame_err  <= 1'b0;
            oParity_err <= 1'b0;
        end else begin
            oValid      <= valid_nxt;
            oFrame_err  <= ferr_nxt;
            oParity_err <= perr_nxt;
            if (valid_nxt)
                oData <= 8'(shift);
        end
    end

    assign oBusy = (state != IDLE);

endmodule
